// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared gate-function, state and index encodings for the response checker
package gate_chk_pkg;
  typedef logic [2:0] func_t;
  typedef logic [1:0] state_t;
  localparam func_t F_AND  = 3'd0;
  localparam func_t F_NAND = 3'd1;
  localparam func_t F_OR   = 3'd2;
  localparam func_t F_NOR  = 3'd3;
  localparam func_t F_XOR  = 3'd4;
  localparam func_t F_XNOR = 3'd5;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;
  localparam logic [7:0] NO_ERR_IDX = 8'hFF;
  function automatic logic func_legal(func_t f);
    return f <= F_XNOR;
  endfunction
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational expected output of the selected two-input gate
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] func,
  input  logic       a,
  input  logic       b,
  output logic       expected
);
  logic w_base;
  // odd encodings are the inverted form of the even gate below them
  assign w_base = (func[2:1] == 2'd0) ? (a & b) : (func[2:1] == 2'd1) ? (a | b) : (a ^ b);
  assign expected = w_base ^ func[0];
endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker: scores observed gate responses against the selected function per session
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int MAX_VEC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] func_sel,
  input  logic       vec_valid,
  input  logic       vec_a,
  input  logic       vec_b,
  input  logic       vec_c,
  output logic       vec_ready,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       cfg_err,
  output logic [7:0] err_cnt,
  output logic [7:0] vec_cnt,
  output logic [7:0] first_err_idx,
  output logic [3:0] coverage
);
  state_t     r_state;
  func_t      r_func;
  logic       r_cfg_err;
  logic [7:0] r_err_cnt;
  logic [7:0] r_vec_cnt;
  logic [7:0] r_first_err_idx;
  logic [3:0] r_coverage;
  logic       w_expected;
  logic       w_accept;
  logic       w_mismatch;
  logic       w_last;

  gate_ref_model u_ref (
    .func     (r_func),
    .a        (vec_a),
    .b        (vec_b),
    .expected (w_expected)
  );

  assign w_accept   = vec_valid && (r_state == S_RUN);
  assign w_mismatch = vec_c != w_expected;
  assign w_last     = r_vec_cnt == 8'(MAX_VEC - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_func          <= F_AND;
      r_cfg_err       <= 1'b0;
      r_err_cnt       <= 8'd0;
      r_vec_cnt       <= 8'd0;
      r_first_err_idx <= NO_ERR_IDX;
      r_coverage      <= 4'd0;
    end else if (r_state == S_IDLE && start) begin
      r_func          <= func_sel;
      r_cfg_err       <= !func_legal(func_sel);
      r_err_cnt       <= 8'd0;
      r_vec_cnt       <= 8'd0;
      r_first_err_idx <= NO_ERR_IDX;
      r_coverage      <= 4'd0;
      r_state         <= func_legal(func_sel) ? S_RUN : S_DONE;
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end else if (w_accept) begin
      r_vec_cnt                 <= r_vec_cnt + 8'd1;
      r_coverage[{vec_a, vec_b}] <= 1'b1;
      // a zero error count means this mismatch is the session's first
      if (w_mismatch) begin
        r_err_cnt <= r_err_cnt + {7'd0, r_err_cnt != 8'hFF};
        if (r_err_cnt == 8'd0) r_first_err_idx <= r_vec_cnt;
      end
      if (w_last) r_state <= S_DONE;
    end
  end

  assign vec_ready     = r_state == S_RUN;
  assign busy          = vec_ready;
  assign done          = r_state == S_DONE;
  assign pass          = (r_err_cnt == 8'd0) && (r_coverage == 4'hF) && !r_cfg_err;
  assign cfg_err       = r_cfg_err;
  assign err_cnt       = r_err_cnt;
  assign vec_cnt       = r_vec_cnt;
  assign first_err_idx = r_first_err_idx;
  assign coverage      = r_coverage;
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: session-level scoreboard with directed and randomized sessions, MAX_VEC=4
module tb_gate_response_checker;
  logic       clk = 1'b0;
  logic       rst, start, vec_valid, vec_a, vec_b, vec_c;
  logic [2:0] func_sel;
  logic       vec_ready, busy, done, pass, cfg_err;
  logic [7:0] err_cnt, vec_cnt, first_err_idx;
  logic [3:0] coverage;
  int         total = 0;
  int         bad = 0;
  logic       va[4], vb[4], vc[4];

  gate_response_checker #(.MAX_VEC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .func_sel(func_sel),
    .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b), .vec_c(vec_c),
    .vec_ready(vec_ready), .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err),
    .err_cnt(err_cnt), .vec_cnt(vec_cnt), .first_err_idx(first_err_idx), .coverage(coverage)
  );

  always #5 clk = ~clk;

  function automatic logic gate_truth(input logic [2:0] f, input logic a, input logic b);
    int ones;
    ones = int'(a) + int'(b);
    case (f)
      3'd0:    return ones == 2;
      3'd1:    return ones != 2;
      3'd2:    return ones >= 1;
      3'd3:    return ones == 0;
      3'd4:    return ones == 1;
      default: return ones != 1;
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string p);
    chk({p, ".ready"}, vec_ready, 0);
    chk({p, ".busy"}, busy, 0);
    chk({p, ".done"}, done, 0);
    chk({p, ".pass"}, pass, 0);
    chk({p, ".cfg_err"}, cfg_err, 0);
    chk({p, ".err_cnt"}, err_cnt, 0);
    chk({p, ".vec_cnt"}, vec_cnt, 0);
    chk({p, ".coverage"}, coverage, 0);
    chk({p, ".first_idx"}, first_err_idx, 255);
  endtask

  task automatic set_vecs(input logic [11:0] v);
    for (int i = 0; i < 4; i++) begin
      va[i] = v[11 - 3*i];
      vb[i] = v[10 - 3*i];
      vc[i] = v[9 - 3*i];
    end
  endtask

  task automatic chk_final(input string p, input int e_err, input int e_first, input int e_cov, input int e_pass);
    chk({p, ".vec_cnt"}, vec_cnt, 4);
    chk({p, ".err_cnt"}, err_cnt, e_err);
    chk({p, ".first_idx"}, first_err_idx, e_first);
    chk({p, ".coverage"}, coverage, e_cov);
    chk({p, ".pass"}, pass, e_pass);
    chk({p, ".cfg_err"}, cfg_err, 0);
    chk({p, ".ready"}, vec_ready, 0);
  endtask

  task automatic run_session(input string p, input logic [2:0] f, input bit gaps);
    int e_err, e_first, e_cov, e_pass;
    e_err = 0; e_first = 255; e_cov = 0;
    for (int i = 0; i < 4; i++) begin
      if (vc[i] != gate_truth(f, va[i], vb[i])) begin
        if (e_err == 0) e_first = i;
        e_err++;
      end
      e_cov |= 1 << (2*int'(va[i]) + int'(vb[i]));
    end
    e_pass = (e_err == 0 && e_cov == 15) ? 1 : 0;
    start = 1'b1; func_sel = f; vec_valid = 1'($urandom);
    vec_a = 1'($urandom); vec_b = 1'($urandom); vec_c = 1'($urandom);
    step();
    start = 1'b0; vec_valid = 1'b0;
    if (f > 3'd5) begin
      chk({p, ".cfg_done"}, done, 1);
      chk({p, ".cfg_err"}, cfg_err, 1);
      chk({p, ".cfg_ready"}, vec_ready, 0);
      chk({p, ".cfg_vec_cnt"}, vec_cnt, 0);
      chk({p, ".cfg_err_cnt"}, err_cnt, 0);
      chk({p, ".cfg_cov"}, coverage, 0);
      chk({p, ".cfg_first"}, first_err_idx, 255);
      chk({p, ".cfg_pass"}, pass, 0);
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      chk({p, ".cfg_done_off"}, done, 0);
      chk({p, ".cfg_ready_off"}, vec_ready, 0);
      chk({p, ".cfg_hold"}, cfg_err, 1);
      chk({p, ".cfg_vec_hold"}, vec_cnt, 0);
      return;
    end
    chk({p, ".run_ready"}, vec_ready, 1);
    chk({p, ".run_busy"}, busy, 1);
    chk({p, ".run_done"}, done, 0);
    chk({p, ".run_vec_cnt"}, vec_cnt, 0);
    chk({p, ".run_err_cnt"}, err_cnt, 0);
    chk({p, ".run_cov"}, coverage, 0);
    chk({p, ".run_first"}, first_err_idx, 255);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          vec_valid = 1'b0; start = 1'($urandom); func_sel = 3'($urandom);
          vec_a = 1'($urandom); vec_b = 1'($urandom); vec_c = 1'($urandom);
          step();
          chk({p, ".gap_ready"}, vec_ready, 1);
          chk({p, ".gap_vec_cnt"}, vec_cnt, i);
        end
      end
      start = 1'($urandom); func_sel = 3'($urandom);
      vec_valid = 1'b1; vec_a = va[i]; vec_b = vb[i]; vec_c = vc[i];
      step();
      vec_valid = 1'b0; start = 1'b0;
      if (i < 3) begin
        chk({p, ".acc_ready"}, vec_ready, 1);
        chk({p, ".acc_vec_cnt"}, vec_cnt, i + 1);
        chk({p, ".acc_done"}, done, 0);
      end
    end
    chk({p, ".done"}, done, 1);
    chk({p, ".done_busy"}, busy, 0);
    chk_final(p, e_err, e_first, e_cov, e_pass);
    vec_valid = 1'b1;
    step();
    chk({p, ".done_pulse"}, done, 0);
    chk_final({p, ".idle"}, e_err, e_first, e_cov, e_pass);
    step();
    vec_valid = 1'b0;
    chk_final({p, ".idle2"}, e_err, e_first, e_cov, e_pass);
  endtask

  initial begin
    logic [2:0] f;
    rst = 1'b1; start = 1'b1; vec_valid = 1'b1; func_sel = 3'd0;
    vec_a = 1'b0; vec_b = 1'b0; vec_c = 1'b0;
    step();
    step();
    chk_reset_values("reset");
    rst = 1'b0; start = 1'b0; vec_valid = 1'b0;
    step();
    set_vecs(12'b001_011_101_110);
    run_session("nand_ok", 3'd1, 1'b0);
    set_vecs(12'b001_011_100_110);
    run_session("nand_err", 3'd1, 1'b0);
    set_vecs(12'b000_000_111_111);
    run_session("and_partial", 3'd0, 1'b0);
    run_session("cfg7", 3'd7, 1'b0);
    run_session("cfg6", 3'd6, 1'b0);
    set_vecs(12'b000_011_101_110);
    run_session("xor_gaps", 3'd4, 1'b1);
    // abort mid-run: two accepts, then reset while a vector is offered
    start = 1'b1; func_sel = 3'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_valid = 1'b1; vec_a = 1'b1; vec_b = 1'b0; vec_c = 1'b1;
      step();
    end
    chk("abort.pre_cnt", vec_cnt, 2);
    rst = 1'b1; vec_valid = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; vec_valid = 1'b0; start = 1'b0;
    chk_reset_values("abort");
    set_vecs(12'b000_011_101_111);
    run_session("after_abort", 3'd2, 1'b1);
    for (int s = 0; s < 30; s++) begin
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      for (int i = 0; i < 4; i++) begin
        va[i] = 1'($urandom); vb[i] = 1'($urandom);
        if (s % 3 == 0) begin
          va[i] = 1'(i >> 1); vb[i] = 1'(i);
        end
        vc[i] = gate_truth(f, va[i], vb[i]) ^ ($urandom_range(0, 5) == 0);
      end
      run_session($sformatf("rand%0d", s), f, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
